if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Receiving end of the fetch stage: accepts each fetched instruction word and its PC+4 value, buffers them in a small FIFO, and presents them in order to decode through a valid/ready handshake.
- Decouples fetch from decode stalls.
- Discards all buffered instructions on a branch/jump flush.
- Sits between the fetch stage (instruction output and PC+4 output) and the decode stage.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, minimum 2.
- INST_W, 32, instruction word width.
- PC_W, 32, width of the PC+4 value carried with each instruction.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_ready  output  1  queue can accept an entry this cycle.
- in_inst  input  INST_W  fetched instruction word.
- in_pc  input  PC_W  PC+4 associated with in_inst.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_inst  output  INST_W  head instruction; 0 (NOP) when empty.
- out_pc  output  PC_W  head PC+4; 0 when empty.
- flush  input  1  synchronous discard of all entries (taken branch/jump).
- count  output  clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Storage and pointers:
  - Circular buffer with DEPTH entries, each holding {inst, pc}.
  - Write pointer wr_ptr and read pointer rd_ptr are each clog2(DEPTH) bits wide.
  - Pointers wrap modulo DEPTH; wrap is natural overflow.
  - Occupancy is tracked by an explicit count register.
- Reset (reset=1 at a clock edge): count=0, wr_ptr=0, rd_ptr=0. Storage contents are don't-care.
- Output values:
  - After reset: out_valid=0, in_ready=1, out_inst=0, out_pc=0, count=0.
  - Reset takes priority over flush, enqueue and dequeue.
- Enqueue:
  - Occurs when in_valid && in_ready.
  - Writes {in_inst, in_pc} at wr_ptr, then wr_ptr increments.
- Dequeue:
  - Occurs when out_valid && out_ready.
  - rd_ptr increments.
- Status signals:
  - in_ready = (count != DEPTH). It is a function of registered state only; there is no combinational path from out_ready, and a full queue with simultaneous dequeue still blocks the enqueue.
  - out_valid = (count != 0).
  - out_inst/out_pc = storage[rd_ptr] when out_valid, else 0.
- Latency:
  - An entry enqueued at edge N is visible on the outputs after edge N (first-word fall-through from storage).
  - There is no same-cycle bypass: with the queue empty and in_valid=1, out_valid stays 0 in that cycle.
- Count update:
  - Enqueue only: +1.
  - Dequeue only: -1.
  - Both: unchanged (pointers both advance).
  - Neither: unchanged.
- Flush (flush=1, reset=0):
  - Next state is count=0, wr_ptr=0, rd_ptr=0.
  - Any enqueue or dequeue in the same cycle is ignored; the incoming in_inst is dropped.
  - One cycle later: out_valid=0, in_ready=1.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Protocol violations:
  - in_valid while in_ready=0: input ignored, state unchanged.
  - out_ready while out_valid=0: no effect.
- Inputs are sampled only at the clock edge; no asynchronous behaviour.

Test Plan:
- Reset then idle: hold reset 2 cycles, release -> count=0, out_valid=0, in_ready=1, out_inst=0x00000000, out_pc=0.
- Fill and block: out_ready=0, enqueue inst 0x20080001/pc 0x4, 0x20090002/0x8, 0x012A4020/0xC, 0xAC080000/0x10 -> count=4, in_ready=0, out_inst=0x20080001, out_pc=0x4. Then a 5th in_valid with 0xDEADBEEF -> ignored, count stays 4.
- Drain in order: from the full state, out_ready=1 for 4 cycles -> out_inst sequence 0x20080001, 0x20090002, 0x012A4020, 0xAC080000; afterwards count=0, out_valid=0, out_inst=0.
- Simultaneous enqueue/dequeue with wrap: keep count=2 while streaming 10 entries with in_valid=out_ready=1 -> count constant at 2, pointers wrap past DEPTH, outputs match input order with a 2-entry lag.
- Flush mid-stream: count=3, assert flush with in_valid=1 and in_inst=0x08000010 -> next cycle count=0, out_valid=0, in_ready=1, and 0x08000010 never appears. Next enqueue of 0x1000FFFF appears at out_inst one cycle later.
- Reset mid-operation and priority: count=2 with reset=1, flush=1, in_valid=1, out_ready=1 in the same cycle -> count=0, out_valid=0, out_pc=0; no stale entry appears after reset.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: buffers fetched {inst, pc+4} pairs and presents them in order to decode.
// First-word fall-through from storage; flush discards everything; no same-cycle bypass.
module if_id_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned INST_W = 32,
    parameter int unsigned PC_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_W-1:0]          in_inst,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INST_W-1:0]          out_inst,
    output logic [PC_W-1:0]            out_pc,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               do_enq;
    logic               do_deq;
    entry_t             head;

    // Status depends on registered occupancy only; no path from out_ready to in_ready.
    always_comb begin
        in_ready  = (cnt != CNT_W'(DEPTH));
        out_valid = (cnt != '0);
        do_enq    = in_valid && in_ready && !flush;
        do_deq    = out_valid && out_ready && !flush;
        head      = mem[rd_ptr];
        out_inst  = out_valid ? head.inst : '0;
        out_pc    = out_valid ? head.pc   : '0;
        count     = cnt;
    end

    // Pointer and occupancy update; reset outranks flush, flush outranks traffic.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_enq && !do_deq) begin
                cnt <= cnt + CNT_W'(1);
            end else if (do_deq && !do_enq) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Storage carries no reset; contents are only observed through count.
    always_ff @(posedge clk) begin
        if (!reset && do_enq) begin
            mem[wr_ptr] <= '{inst: in_inst, pc: in_pc};
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a queue-based reference model of the FIFO contents.
module tb_if_id_queue;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        flush;
    logic [2:0]  count;

    ent_t sb[$];
    int   vec = 0;
    int   err = 0;

    if_id_queue #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare status and head against the model; on a dequeue, pop and compare the leaving entry.
    task automatic chk(input string tag);
        ent_t e;
        int   n;
        n = sb.size();
        cmp({tag, ".count"},     64'(count),     64'(n));
        cmp({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
        cmp({tag, ".in_ready"},  64'(in_ready),  64'(n != DEPTH));
        if (n == 0) begin
            cmp({tag, ".out_inst"}, 64'(out_inst), 64'(0));
            cmp({tag, ".out_pc"},   64'(out_pc),   64'(0));
        end else begin
            e = sb[0];
            cmp({tag, ".out_inst"}, 64'(out_inst), 64'(e.inst));
            cmp({tag, ".out_pc"},   64'(out_pc),   64'(e.pc));
        end
    endtask

    // Advance the model using the currently driven inputs, then cross one rising edge.
    task automatic tick();
        bit   enq;
        bit   deq;
        ent_t e;
        if (reset || flush) begin
            sb.delete();
        end else begin
            enq = in_valid && (sb.size() != DEPTH);
            deq = out_ready && (sb.size() != 0);
            if (deq) begin
                e = sb.pop_front();
                vec++;
                assert (out_inst === e.inst && out_pc === e.pc) else begin
                    err++;
                    $error("FAIL pop observed=%0h/%0h expected=%0h/%0h", out_inst, out_pc, e.inst, e.pc);
                end
            end
            if (enq) sb.push_back('{inst: in_inst, pc: in_pc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string tag);
        chk(tag);
        tick();
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p, input logic r);
        in_valid  = v;
        in_inst   = i;
        in_pc     = p;
        out_ready = r;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        tick();
        reset = 1'b0;
        cmp("rst.count", 64'(count), 64'(0));
        cmp("rst.out_inst", 64'(out_inst), 64'(0));
        cycle("idle");

        // Fill to full with decode stalled, then a blocked fifth write.
        drive(1'b1, 32'h20080001, 32'h4, 1'b0);  cycle("fill0");
        drive(1'b1, 32'h20090002, 32'h8, 1'b0);  cycle("fill1");
        drive(1'b1, 32'h012A4020, 32'hC, 1'b0);  cycle("fill2");
        drive(1'b1, 32'hAC080000, 32'h10, 1'b0); cycle("fill3");
        cmp("full.in_ready", 64'(in_ready), 64'(0));
        cmp("full.head", 64'(out_inst), 64'h20080001);
        drive(1'b1, 32'hDEADBEEF, 32'h14, 1'b0); cycle("blocked");
        drive(1'b1, 32'hDEADBEEF, 32'h14, 1'b1); cycle("full_enq_deq");
        cmp("full_deq.count", 64'(count), 64'(3));

        // Drain remaining entries in order.
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) cycle("drain");
        cycle("drained");
        cmp("empty.out_inst", 64'(out_inst), 64'(0));

        // Prime two entries, then stream ten through with the pointers wrapping.
        drive(1'b1, 32'h11110000, 32'h100, 1'b0); cycle("prime0");
        drive(1'b1, 32'h11110001, 32'h104, 1'b0); cycle("prime1");
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h22220000 + 32'(k), 32'h200 + 32'(4 * k), 1'b1);
            cycle("stream");
            cmp("stream.count", 64'(count), 64'(2));
        end

        // Reach three entries, then flush with a write pending.
        drive(1'b1, 32'h33330000, 32'h300, 1'b0); cycle("pre_flush");
        cmp("pre_flush.count", 64'(count), 64'(3));
        drive(1'b1, 32'h08000010, 32'h304, 1'b1);
        flush = 1'b1;
        cycle("flush");
        flush = 1'b0;
        cmp("post_flush.count", 64'(count), 64'(0));
        drive(1'b1, 32'h1000FFFF, 32'h308, 1'b0); cycle("after_flush_enq");
        drive(1'b0, 32'h0, 32'h0, 1'b0);          cycle("after_flush_vis");
        cmp("after_flush.head", 64'(out_inst), 64'h1000FFFF);

        // Reset outranks flush and traffic in the same cycle.
        drive(1'b1, 32'h44440000, 32'h400, 1'b0); cycle("pre_rst");
        cmp("pre_rst.count", 64'(count), 64'(2));
        drive(1'b1, 32'h55550000, 32'h500, 1'b1);
        flush = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        cycle("post_rst");
        cmp("post_rst.out_pc", 64'(out_pc), 64'(0));
        cycle("post_rst_idle");
        drive(1'b1, 32'h66660000, 32'h600, 1'b0); cycle("fresh_enq");
        drive(1'b0, 32'h0, 32'h0, 1'b1);          cycle("fresh_deq");
        cycle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
